stage11_bf_sequencer: RTL and testbench
=======================================

// Module: stage11_bf_sequencer
// PURPOSE
//  Control/address generator for radix-2 FFT stage 11, directly upstream of tfProvider11. Per frame it issues
//  one butterfly per cycle: it reads the operand pair from data BRAM and pulses tf_en so that tfProvider11
//  presents the matching twiddle factor on the same cycle as the operands. After the butterfly pipeline latency
//  it issues the write-back addresses, then signals completion.
// PARAMETERS
//  DATA_ADDR_LEN  13   log2(points); 8192-point frame
//  STAGE_NUM      11   stage index (1-based); span = 2^(STAGE_NUM-1) = 1024
//  TF_ADDR_LEN    10   log2(twiddle count); must equal STAGE_NUM-1
//  BF_LATENCY     12   cycles from operand-valid to butterfly result valid (>=1)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous reset, ACTIVE-LOW
//  start      in   1               frame start pulse; sampled only in IDLE
//  hold       in   1               stall issue (no new butterfly this cycle)
//  busy       out  1               high from accepted start to done
//  done       out  1               one-cycle pulse after last write-back
//  rd_en      out  1               data BRAM read enable (both ports)
//  rd_addr_a  out  DATA_ADDR_LEN   upper-wing operand x1 address
//  rd_addr_b  out  DATA_ADDR_LEN   lower-wing operand x2 address
//  tf_en      out  1               to tfProvider11.en; identical to rd_en
//  op_valid   out  1               operands and twiddle valid this cycle (rd_en delayed 1)
//  wr_en      out  1               write-back enable (op_valid delayed BF_LATENCY)
//  wr_addr_a  out  DATA_ADDR_LEN   y1 address, aligned with wr_en
//  wr_addr_b  out  DATA_ADDR_LEN   y2 address, aligned with wr_en
// BEHAVIOUR
//  - Reset (rst=0): state IDLE, counters 0, all outputs 0, address pipeline cleared. Asynchronous assert,
//    synchronous deassert handled by the top. tfProvider11 shares this reset (inverted) so both restart at 0.
//  - FSM: IDLE -start-> RUN; RUN -last issue-> DRAIN; DRAIN -last wr_en-> DONE; DONE -> IDLE (1 cycle, done=1).
//  - busy = (state != IDLE). start in RUN/DRAIN/DONE is ignored; start in IDLE with hold=1 enters RUN, no issue.
//  - Issue counter cnt (DATA_ADDR_LEN-1 bits, 0..4095): in RUN with hold=0, rd_en=tf_en=1 and cnt increments.
//    hold=1: rd_en=tf_en=0, cnt holds, addresses hold. Last issue = cnt==4095 with hold=0.
//  - Addresses registered with rd_en: k=cnt[STAGE_NUM-2:0], g=cnt[DATA_ADDR_LEN-2:STAGE_NUM-1];
//    rd_addr_a={g,1'b0,k}, rd_addr_b={g,1'b1,k}. Stage 11: 4 groups x 1024 butterflies, b = a + 1024.
//  - Twiddle alignment: tfProvider11 address increments per tf_en and wraps mod 2^TF_ADDR_LEN, so twiddle
//    index == k for every issue; 4096 issues per frame is a multiple of 1024, so provider ends each frame at 0.
//  - op_valid = rd_en delayed 1 cycle (BRAM and tf ROM both 1-cycle read latency).
//  - Write pipeline: shift register depth BF_LATENCY carrying {valid, addr_a, addr_b}; shifts every cycle
//    regardless of hold (butterfly pipeline is free-running). wr_* = tail of shift register.
//  - Issue-to-write latency = 1 + BF_LATENCY cycles. DRAIN exits when the final valid leaves the pipeline.
//  - Back-to-back frames: next start accepted earliest the cycle after done (in IDLE).
//  - rd_addr_* and wr_addr_* hold last value when their enable is low; consumers qualify with enables.
// STRUCTURE
//  - Shared package: DATA_ADDR_LEN, TF_ADDR_LEN, BF_LATENCY constants; FSM state encoding (IDLE,RUN,DRAIN,DONE).
//  - One sub-module: bf_addr_delay (parameterised depth/width shift register with async active-low reset),
//    used for the write-back address/valid pipeline.
//  - tfProvider11 instantiated by the stage top, not inside this block.
// TESTING
//  1. Reset then start, hold=0 -> rd_en high 4096 consecutive cycles; first pair (0,1024), pair 1024 = (2048,3072),
//     last (7167,8191); done exactly 4096+1+BF_LATENCY+1 cycles after issue start.
//  2. Paired with tfProvider11 model -> on every op_valid, twiddle index == rd_addr_a[9:0]; provider addr 0 at done.
//  3. hold asserted for issues 100..109 -> no rd_en/tf_en those cycles, cnt resumes at 100, done delayed by 10.
//  4. start pulsed mid-RUN and in DRAIN -> ignored; cnt and busy unaffected; exactly one done.
//  5. rst low at issue 2000 -> all outputs 0 same cycle; after release + start, frame restarts at pair (0,1024).
//  6. Two frames, second start the cycle after done -> second frame addresses identical to first, wr_en count 8192.

Source files
------------

// File: rtl/stage11_bf_sequencer_pkg.sv
// Shared constants, state encoding and address helper for the stage-11 butterfly sequencer.
// Stage 11 pairs points 1024 apart: 4 groups of 1024 butterflies over an 8192-point frame.
package stage11_bf_sequencer_pkg;

    localparam int DATA_ADDR_LEN = 13;
    localparam int STAGE_NUM     = 11;
    localparam int TF_ADDR_LEN   = 10;
    localparam int BF_LATENCY    = 12;
    localparam int CNT_LEN       = DATA_ADDR_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // Insert the wing bit between group and in-group index: {g, lower, k}.
    function automatic logic [DATA_ADDR_LEN-1:0] wing_addr(input logic [CNT_LEN-1:0] cnt,
                                                           input logic lower);
        return {cnt[CNT_LEN-1:STAGE_NUM-1], lower, cnt[STAGE_NUM-2:0]};
    endfunction

endpackage

// File: rtl/stage11_bf_sequencer_bf_addr_delay.sv
// Fixed-depth shift register carrying write-back valid and addresses alongside the
// free-running butterfly pipeline; shifts every cycle.
module bf_addr_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_reg [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) pipe_reg[gi] <= '0;
                else      pipe_reg[gi] <= din;
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) pipe_reg[gi] <= '0;
                else      pipe_reg[gi] <= pipe_reg[gi-1];
            end
        end
    end

    assign dout = pipe_reg[DEPTH-1];

endmodule

// File: rtl/stage11_bf_sequencer.sv
// Read/twiddle/write-back address sequencer for FFT stage 11: one butterfly issue per
// cycle, write-back addresses delayed to match the butterfly pipeline, then a done pulse.
module stage11_bf_sequencer
    import stage11_bf_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [DATA_ADDR_LEN-1:0] rd_addr_a,
    output logic [DATA_ADDR_LEN-1:0] rd_addr_b,
    output logic                     tf_en,
    output logic                     op_valid,
    output logic                     wr_en,
    output logic [DATA_ADDR_LEN-1:0] wr_addr_a,
    output logic [DATA_ADDR_LEN-1:0] wr_addr_b
);

    localparam int                    DRAIN_LEN  = $clog2(BF_LATENCY + 2);
    localparam logic [DRAIN_LEN-1:0]  DRAIN_INIT = DRAIN_LEN'(BF_LATENCY + 1);
    localparam logic [CNT_LEN-1:0]    CNT_LAST   = {CNT_LEN{1'b1}};
    localparam int                    WB_WIDTH   = 1 + 2 * DATA_ADDR_LEN;

    logic rst_meta_reg, rst_sync_reg;

    // Reset asserts asynchronously but releases two clocks after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    seq_state_t               state_reg;
    logic [CNT_LEN-1:0]       cnt_reg;
    logic [DRAIN_LEN-1:0]     drain_reg;
    logic                     rd_en_reg, op_valid_reg, done_reg;
    logic [DATA_ADDR_LEN-1:0] rd_addr_a_reg, rd_addr_b_reg;
    logic [DATA_ADDR_LEN-1:0] op_addr_a_reg, op_addr_b_reg;

    always_ff @(posedge clk or negedge rst_sync_reg) begin
        if (!rst_sync_reg) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            drain_reg     <= '0;
            rd_en_reg     <= 1'b0;
            op_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            rd_addr_a_reg <= '0;
            rd_addr_b_reg <= '0;
            op_addr_a_reg <= '0;
            op_addr_b_reg <= '0;
        end else begin
            rd_en_reg     <= 1'b0;
            done_reg      <= 1'b0;
            // Operand/twiddle data arrive one cycle after the read request.
            op_valid_reg  <= rd_en_reg;
            op_addr_a_reg <= rd_addr_a_reg;
            op_addr_b_reg <= rd_addr_b_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (start) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (!hold) begin
                        rd_en_reg     <= 1'b1;
                        rd_addr_a_reg <= wing_addr(cnt_reg, 1'b0);
                        rd_addr_b_reg <= wing_addr(cnt_reg, 1'b1);
                        cnt_reg       <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= ST_DRAIN;
                            drain_reg <= DRAIN_INIT;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Zero when the final write-back has just been presented.
                    if (drain_reg == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_reg <= drain_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    logic [WB_WIDTH-1:0] wb_in, wb_out;

    assign wb_in = {op_valid_reg, op_addr_a_reg, op_addr_b_reg};

    bf_addr_delay #(
        .DEPTH (BF_LATENCY),
        .WIDTH (WB_WIDTH)
    ) u_wb_delay (
        .clk  (clk),
        .rst  (rst_sync_reg),
        .din  (wb_in),
        .dout (wb_out)
    );

    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign rd_en     = rd_en_reg;
    assign tf_en     = rd_en_reg;
    assign rd_addr_a = rd_addr_a_reg;
    assign rd_addr_b = rd_addr_b_reg;
    assign op_valid  = op_valid_reg;
    assign wr_en     = wb_out[WB_WIDTH-1];
    assign wr_addr_a = wb_out[2*DATA_ADDR_LEN-1:DATA_ADDR_LEN];
    assign wr_addr_b = wb_out[DATA_ADDR_LEN-1:0];

endmodule

// File: tb/tb_stage11_bf_sequencer.sv
// Scoreboard bench for the stage-11 sequencer with a behavioural tfProvider11 address model.
module tb_stage11_bf_sequencer;
    import stage11_bf_sequencer_pkg::*;

    localparam int N_ISSUE = 4096;
    localparam int TIMEOUT = 6000;

    logic clk = 1'b0;
    logic rst, start, hold;
    logic busy, done, rd_en, tf_en, op_valid, wr_en;
    logic [DATA_ADDR_LEN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

    always #5 clk = ~clk;

    stage11_bf_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tf_en     (tf_en),
        .op_valid  (op_valid),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Expected upper-wing address of issue i: group i/1024 spans 2048 points.
    function automatic int exp_a(input int i);
        return (i / 1024) * 2048 + (i % 1024);
    endfunction

    // tfProvider11 model: address advances on tf_en, ROM data (the index) one cycle later.
    logic [TF_ADDR_LEN-1:0] tf_addr, tw_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tf_addr <= '0;
            tw_q    <= '0;
        end else if (tf_en) begin
            tw_q    <= tf_addr;
            tf_addr <= tf_addr + 1'b1;
        end
    end

    typedef struct {
        int a;
        int b;
        int c;
    } wb_t;

    wb_t sb_q[$];
    int  cyc = 0, issue_idx = 0, op_idx = 0, first_rd = 0;
    int  rd_total = 0, wr_total = 0, done_total = 0, exp_stall = 0;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        wb_t e;
        int  ea;
        cyc++;
        if (!rst) begin
            sb_q.delete();
            issue_idx = 0;
            op_idx    = 0;
            prev_rd   = 1'b0;
        end else begin
            check_eq("tf_en_eq_rd_en", tf_en, rd_en);
            check_eq("op_valid_delay", op_valid, prev_rd);
            if (rd_en || op_valid || wr_en || done) check_eq("busy_active", busy, 1);
            if (rd_en) begin
                if (issue_idx == 0) first_rd = cyc;
                ea = exp_a(issue_idx);
                check_eq("rd_addr_a", rd_addr_a, ea);
                check_eq("rd_addr_b", rd_addr_b, ea + 1024);
                sb_q.push_back('{ea, ea + 1024, cyc});
                issue_idx++;
                rd_total++;
            end
            if (op_valid) begin
                check_eq("tw_index", tw_q, op_idx % 1024);
                op_idx++;
            end
            if (wr_en) begin
                if (sb_q.size() == 0) begin
                    check_eq("wr_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("wr_addr_a", wr_addr_a, e.a);
                    check_eq("wr_addr_b", wr_addr_b, e.b);
                    check_eq("wr_latency", cyc - e.c, 1 + BF_LATENCY);
                end
                wr_total++;
            end
            if (done) begin
                done_total++;
                // Inclusive span: 4096 issues + read latency + butterfly latency + done cycle.
                check_eq("done_span", cyc - first_rd + 1, N_ISSUE + 1 + BF_LATENCY + 1 + exp_stall);
                check_eq("done_issues", issue_idx, N_ISSUE);
                check_eq("done_sb_empty", sb_q.size(), 0);
                check_eq("tf_addr_at_done", tf_addr, 0);
                issue_idx = 0;
                op_idx    = 0;
            end
            prev_rd = rd_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_issue(input int addr, input string tag);
        int n = 0;
        while (!(rd_en && rd_addr_a == DATA_ADDR_LEN'(addr)) && n < TIMEOUT) begin
            tick();
            n++;
        end
        check_eq(tag, n < TIMEOUT, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < TIMEOUT) begin
            tick();
            n++;
        end
        check_eq(tag, done, 1);
        tick();
        check_eq("busy_after_done", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, rd_en, 0);
        check_eq({tag, "_tf_en"}, tf_en, 0);
        check_eq({tag, "_op_valid"}, op_valid, 0);
        check_eq({tag, "_wr_en"}, wr_en, 0);
        check_eq({tag, "_rd_addr"}, {rd_addr_a, rd_addr_b}, 0);
        check_eq({tag, "_wr_addr"}, {wr_addr_a, wr_addr_b}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got 0 want 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, r0;
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (4) tick();
        $display("TXN reset  checks=%0d errors=%0d", n_checks, n_errors);

        r0 = rd_total;
        pulse_start();
        wait_done("basic_done");
        check_eq("basic_rd_count", rd_total - r0, N_ISSUE);
        $display("TXN basic  checks=%0d errors=%0d", n_checks, n_errors);

        exp_stall = 10;
        pulse_start();
        wait_issue(99, "hold_reach_99");
        hold = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done("hold_done");
        exp_stall = 0;
        $display("TXN hold   checks=%0d errors=%0d", n_checks, n_errors);

        d0 = done_total;
        pulse_start();
        wait_issue(exp_a(500), "ign_reach_500");
        pulse_start();
        check_eq("ign_busy_run", busy, 1);
        wait_issue(exp_a(N_ISSUE - 1), "ign_reach_last");
        tick();
        pulse_start();
        check_eq("ign_busy_drain", busy, 1);
        wait_done("ign_done");
        repeat (30) tick();
        check_eq("ign_done_count", done_total - d0, 1);
        check_eq("ign_idle", busy, 0);
        $display("TXN ignore checks=%0d errors=%0d", n_checks, n_errors);

        d0 = done_total;
        pulse_start();
        wait_issue(exp_a(2000), "rst_reach_2000");
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check_eq("midrst_no_done", done_total - d0, 0);
        pulse_start();
        wait_done("midrst_done");
        $display("TXN midrst checks=%0d errors=%0d", n_checks, n_errors);

        w0 = wr_total;
        d0 = done_total;
        pulse_start();
        wait_done("b2b_done1");
        pulse_start();
        wait_done("b2b_done2");
        check_eq("b2b_wr_count", wr_total - w0, 2 * N_ISSUE);
        check_eq("b2b_done_count", done_total - d0, 2);
        $display("TXN b2b    checks=%0d errors=%0d", n_checks, n_errors);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
